signed_divider: RTL and testbench

- Iterative signed integer divider; the inverse of the datapath's combinational signed multiplier.
- Takes an outWidth-bit dividend (product-width operand) and an inWidth-bit divisor.
- Returns an outWidth-bit quotient and an inWidth-bit remainder after a fixed multi-cycle latency.
- Restoring algorithm, one quotient bit per clock, start/valid handshake; used where results from the multiplier domain must be scaled back down.

---
 rtl/signed_divider.sv | 139 +++++++++++++
 tb/tb_signed_divider.sv | 235 +++++++++++++++++++++++
 2 files changed

// File: rtl/signed_divider.sv
// Iterative restoring signed divider: outWidth-bit dividend / inWidth-bit divisor, one quotient bit per clock.
// Define DIV_ZERO_SAT_EN to saturate the quotient by the dividend's sign on divide-by-zero instead of returning -1.
module signed_divider #(
    parameter int inWidth  = 8,
    parameter int outWidth = 16
) (
    input  logic                clk,
    input  logic                rst,
    input  logic                start,
    input  logic [outWidth-1:0] dividend,
    input  logic [inWidth-1:0]  divisor,
    output logic                ready,
    output logic                valid,
    output logic [outWidth-1:0] quotient,
    output logic [inWidth-1:0]  remainder,
    output logic                divByZero,
    output logic                overflow
);

    localparam int cntWidth = $clog2(outWidth);

    localparam logic [1:0] IDLE = 2'd0;
    localparam logic [1:0] CALC = 2'd1;
    localparam logic [1:0] FIX  = 2'd2;
    localparam logic [1:0] DONE = 2'd3;

    logic [1:0]          r_state;
    logic                r_negQ;
    logic                r_negR;
    logic                r_ovfCase;
    logic [outWidth-1:0] r_dvdMag;
    logic [inWidth-1:0]  r_dvsMag;
    logic [inWidth:0]    r_rem;
    logic [cntWidth-1:0] r_cnt;
    logic [outWidth-1:0] r_quotient;
    logic [inWidth-1:0]  r_remainder;
    logic                r_divByZero;
    logic                r_overflow;

    logic                w_dvdNeg;
    logic                w_dvsNeg;
    logic [outWidth-1:0] w_dvdAbs;
    logic [inWidth-1:0]  w_dvsAbs;
    logic [inWidth+1:0]  w_diff;
    logic                w_qBit;
    logic [inWidth:0]    w_remNext;
    logic                w_ovfDetect;
    logic [outWidth-1:0] w_zeroQuot;

    assign w_dvdNeg = dividend[outWidth-1];
    assign w_dvsNeg = divisor[inWidth-1];
    assign w_dvdAbs = w_dvdNeg ? -dividend : dividend;
    assign w_dvsAbs = w_dvsNeg ? -divisor : divisor;

    // The shifted partial remainder is always below 2*|divisor|, so the extra MSB of the difference is its sign.
    assign w_diff    = {r_rem, r_dvdMag[outWidth-1]} - {2'b00, r_dvsMag};
    assign w_qBit    = ~w_diff[inWidth+1];
    assign w_remNext = w_qBit ? w_diff[inWidth:0] : {r_rem[inWidth-1:0], r_dvdMag[outWidth-1]};

    assign w_ovfDetect = w_dvdNeg && (dividend[outWidth-2:0] == '0) && (&divisor);

`ifdef DIV_ZERO_SAT_EN
    assign w_zeroQuot = w_dvdNeg ? {1'b1, {(outWidth-1){1'b0}}} : {1'b0, {(outWidth-1){1'b1}}};
`else
    assign w_zeroQuot = '1;
`endif

    always_ff @(posedge clk) begin
        if (rst) begin
            r_state     <= IDLE;
            r_negQ      <= 1'b0;
            r_negR      <= 1'b0;
            r_ovfCase   <= 1'b0;
            r_dvdMag    <= '0;
            r_dvsMag    <= '0;
            r_rem       <= '0;
            r_cnt       <= '0;
            r_quotient  <= '0;
            r_remainder <= '0;
            r_divByZero <= 1'b0;
            r_overflow  <= 1'b0;
        end else begin
            case (r_state)
                IDLE: begin
                    if (start) begin
                        r_negQ    <= w_dvdNeg ^ w_dvsNeg;
                        r_negR    <= w_dvdNeg;
                        r_ovfCase <= w_ovfDetect;
                        r_dvdMag  <= w_dvdAbs;
                        r_dvsMag  <= w_dvsAbs;
                        r_rem     <= '0;
                        r_cnt     <= cntWidth'(outWidth - 1);
                        // Divide-by-zero skips the iteration and publishes its fixed result straight away.
                        if (divisor == '0) begin
                            r_state     <= DONE;
                            r_quotient  <= w_zeroQuot;
                            r_remainder <= '0;
                            r_divByZero <= 1'b1;
                            r_overflow  <= 1'b0;
                        end else begin
                            r_state <= CALC;
                        end
                    end
                end
                CALC: begin
                    r_rem    <= w_remNext;
                    r_dvdMag <= {r_dvdMag[outWidth-2:0], w_qBit};
                    if (r_cnt == '0) begin
                        r_state <= FIX;
                    end else begin
                        r_cnt <= r_cnt - cntWidth'(1);
                    end
                end
                FIX: begin
                    // Most-negative / -1 yields magnitude 2^(outWidth-1), which already reads back as the wrapped quotient.
                    r_quotient  <= r_negQ ? -r_dvdMag : r_dvdMag;
                    r_remainder <= r_negR ? -r_rem[inWidth-1:0] : r_rem[inWidth-1:0];
                    r_divByZero <= 1'b0;
                    r_overflow  <= r_ovfCase;
                    r_state     <= DONE;
                end
                DONE: begin
                    r_state <= IDLE;
                end
                default: begin
                    r_state <= IDLE;
                end
            endcase
        end
    end

    assign ready     = (r_state == IDLE);
    assign valid     = (r_state == DONE);
    assign quotient  = r_quotient;
    assign remainder = r_remainder;
    assign divByZero = r_divByZero;
    assign overflow  = r_overflow;

endmodule

// File: tb/tb_signed_divider.sv
// Self-checking bench for signed_divider (inWidth=8, outWidth=16): directed cases plus random operands
// compared against plain integer division; honours DIV_ZERO_SAT_EN when defined.
module tb_signed_divider;

    logic        clk;
    logic        rst;
    logic        start;
    logic [15:0] dividend;
    logic [7:0]  divisor;
    logic        ready;
    logic        valid;
    logic [15:0] quotient;
    logic [7:0]  remainder;
    logic        divByZero;
    logic        overflow;

    int errors = 0;
    int checks = 0;
    int edgeCnt = 0;

    signed_divider #(.inWidth(8), .outWidth(16)) dut (
        .clk(clk),
        .rst(rst),
        .start(start),
        .dividend(dividend),
        .divisor(divisor),
        .ready(ready),
        .valid(valid),
        .quotient(quotient),
        .remainder(remainder),
        .divByZero(divByZero),
        .overflow(overflow)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    always @(posedge clk) edgeCnt <= edgeCnt + 1;

    task automatic checkOutput(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("[TB] FAIL %s: observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    // Reference behaviour from plain integer arithmetic: truncating division, remainder follows the dividend.
    task automatic refModel(input int a, input int b, output logic [15:0] q, output logic [7:0] r,
                            output logic dz, output logic ov);
        if (b == 0) begin
            dz = 1'b1;
            ov = 1'b0;
            r  = 8'h00;
`ifdef DIV_ZERO_SAT_EN
            q = (a < 0) ? 16'h8000 : 16'h7FFF;
`else
            q = 16'hFFFF;
`endif
        end else begin
            q  = 16'(a / b);
            r  = 8'(a % b);
            dz = 1'b0;
            ov = (a == -32768) && (b == -1);
        end
    endtask

    task automatic applyStimulus(input logic [15:0] a, input logic [7:0] b, input int glitchAt, input string tag);
        logic [15:0] expQ;
        logic [7:0]  expR;
        logic        expDz;
        logic        expOv;
        int          lat;
        int          n;
        logic        sawReady;
        refModel(int'($signed(a)), int'($signed(b)), expQ, expR, expDz, expOv);
        n = 0;
        while (ready !== 1'b1 && n < 50) begin
            @(negedge clk);
            n++;
        end
        checkOutput({tag, " ready before start"}, 32'(ready), 32'd1);
        dividend = a;
        divisor  = b;
        start    = 1'b1;
        @(negedge clk);
        start    = 1'b0;
        lat      = 0;
        sawReady = 1'b0;
        while (valid !== 1'b1 && lat < 40) begin
            if (ready !== 1'b0) sawReady = 1'b1;
            if (lat == glitchAt) begin
                start    = 1'b1;
                dividend = 16'd9;
                divisor  = 8'd2;
            end else begin
                start = 1'b0;
            end
            @(negedge clk);
            lat++;
        end
        start = 1'b0;
        if (ready !== 1'b0) sawReady = 1'b1;
        checkOutput({tag, " latency"}, 32'(lat), (b == 8'h00) ? 32'd0 : 32'd17);
        checkOutput({tag, " ready while busy"}, 32'(sawReady), 32'd0);
        checkOutput({tag, " quotient"}, 32'(quotient), 32'(expQ));
        checkOutput({tag, " remainder"}, 32'(remainder), 32'(expR));
        checkOutput({tag, " divByZero"}, 32'(divByZero), 32'(expDz));
        checkOutput({tag, " overflow"}, 32'(overflow), 32'(expOv));
        @(negedge clk);
        checkOutput({tag, " valid width"}, 32'(valid), 32'd0);
        checkOutput({tag, " quotient held"}, 32'(quotient), 32'(expQ));
    endtask

    initial begin
        logic [15:0] ra;
        logic [7:0]  rb;
        logic [15:0] expQ;
        logic [7:0]  expR;
        logic        expDz;
        logic        expOv;
        int          validSeen;
        int          lastValidEdge;
        int          n;
        logic [15:0] bbA [3];
        logic [7:0]  bbB [3];

        rst      = 1'b1;
        start    = 1'b0;
        dividend = '0;
        divisor  = '0;
        @(negedge clk);
        @(negedge clk);
        checkOutput("reset ready", 32'(ready), 32'd1);
        checkOutput("reset valid", 32'(valid), 32'd0);
        checkOutput("reset quotient", 32'(quotient), 32'd0);
        checkOutput("reset remainder", 32'(remainder), 32'd0);
        checkOutput("reset flags", {30'd0, divByZero, overflow}, 32'd0);
        rst = 1'b0;
        @(negedge clk);

        $display("[TB] 1000/7 with an ignored start pulse during CALC");
        applyStimulus(16'd1000, 8'd7, 3, "1000/7");
        validSeen = 0;
        for (int i = 0; i < 25; i++) begin
            @(negedge clk);
            if (valid === 1'b1) validSeen++;
        end
        checkOutput("ignored start no extra valid", 32'(validSeen), 32'd0);
        checkOutput("ignored start quotient", 32'(quotient), 32'h008E);
        checkOutput("ignored start remainder", 32'(remainder), 32'd6);

        $display("[TB] sign combinations and boundaries");
        applyStimulus(-16'sd1000, 8'd7, -1, "-1000/7");
        applyStimulus(16'd1000, -8'sd7, -1, "1000/-7");
        applyStimulus(-16'sd1000, -8'sd7, -1, "-1000/-7");
        applyStimulus(16'h8000, 8'hFF, -1, "-32768/-1");
        applyStimulus(16'h8000, 8'h80, -1, "-32768/-128");
        applyStimulus(16'd5, 8'd0, -1, "5/0");
        applyStimulus(-16'sd5, 8'd0, -1, "-5/0");
        applyStimulus(16'h7FFF, 8'h80, -1, "32767/-128");
        applyStimulus(16'd3, 8'd7, -1, "3/7");

        $display("[TB] reset in the middle of an operation");
        n = 0;
        while (ready !== 1'b1 && n < 50) begin
            @(negedge clk);
            n++;
        end
        dividend = 16'd1234;
        divisor  = 8'd5;
        start    = 1'b1;
        @(negedge clk);
        start = 1'b0;
        for (int i = 0; i < 5; i++) @(negedge clk);
        rst = 1'b1;
        @(negedge clk);
        checkOutput("midop reset ready", 32'(ready), 32'd1);
        checkOutput("midop reset valid", 32'(valid), 32'd0);
        checkOutput("midop reset quotient", 32'(quotient), 32'd0);
        checkOutput("midop reset remainder", 32'(remainder), 32'd0);
        checkOutput("midop reset flags", {30'd0, divByZero, overflow}, 32'd0);
        rst = 1'b0;
        validSeen = 0;
        for (int i = 0; i < 25; i++) begin
            @(negedge clk);
            if (valid === 1'b1) validSeen++;
        end
        checkOutput("midop reset no valid", 32'(validSeen), 32'd0);

        $display("[TB] back-to-back with start held high");
        bbA[0] = 16'd1000;  bbB[0] = 8'd7;
        bbA[1] = -16'sd300; bbB[1] = -8'sd9;
        bbA[2] = 16'h7FFF;  bbB[2] = 8'd127;
        dividend = bbA[0];
        divisor  = bbB[0];
        start    = 1'b1;
        lastValidEdge = 0;
        for (int i = 0; i < 3; i++) begin
            n = 0;
            while (valid !== 1'b1 && n < 40) begin
                @(negedge clk);
                n++;
            end
            refModel(int'($signed(bbA[i])), int'($signed(bbB[i])), expQ, expR, expDz, expOv);
            checkOutput($sformatf("b2b%0d valid", i), 32'(valid), 32'd1);
            checkOutput($sformatf("b2b%0d quotient", i), 32'(quotient), 32'(expQ));
            checkOutput($sformatf("b2b%0d remainder", i), 32'(remainder), 32'(expR));
            if (i > 0) checkOutput($sformatf("b2b%0d spacing", i), 32'(edgeCnt - lastValidEdge), 32'd19);
            lastValidEdge = edgeCnt;
            if (i < 2) begin
                dividend = bbA[i+1];
                divisor  = bbB[i+1];
            end
            @(negedge clk);
        end
        start = 1'b0;

        $display("[TB] random operands");
        for (int i = 0; i < 150; i++) begin
            ra = ($urandom_range(0, 15) == 0) ? 16'h8000 : 16'($urandom);
            case ($urandom_range(0, 9))
                0:       rb = 8'h00;
                1:       rb = 8'hFF;
                2:       rb = 8'h80;
                default: rb = 8'($urandom);
            endcase
            applyStimulus(ra, rb, -1, $sformatf("rand%0d %0d/%0d", i, $signed(ra), $signed(rb)));
        end

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
